// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-RAM arbiter: FSM state encoding and port ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: bounded burst tenure,
// round-robin tie break, and read tags routing returned data to its issuer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          Wr0,
  input  logic          Wr1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData0,
  input  logic [DW-1:0] WData1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          RValid0,
  output logic          RValid1,
  output logic [DW-1:0] RData,
  output logic [AW-1:0] Mem_Addr,
  output logic          Mem_Wr,
  output logic [DW-1:0] Mem_WData,
  input  logic [DW-1:0] Mem_RData
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] MAX_B = (CW+1)'(MAX_BURST);

  arb_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last, last_nx;
  logic [1:0]    rd_tag;

  logic          own;      // port id of the current owner (valid in OWNx)
  logic          own_req, oth_req;
  logic [CW:0]   cnt_inc;

  always_comb begin
    Gnt0      = (state == OWN0) && Req0;
    Gnt1      = (state == OWN1) && Req1;
    Mem_Addr  = '0;
    Mem_WData = '0;
    if (Gnt0) begin
      Mem_Addr  = Addr0;
      Mem_WData = WData0;
    end else if (Gnt1) begin
      Mem_Addr  = Addr1;
      Mem_WData = WData1;
    end
    Mem_Wr = (Gnt0 & Wr0) | (Gnt1 & Wr1);

    own      = (state == OWN1);
    own_req  = own ? Req1 : Req0;
    oth_req  = own ? Req0 : Req1;
    cnt_inc  = {1'b0, cnt} + (CW+1)'(1);
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        // On a tie the port that did not own last wins.
        if (Req0 && (!Req1 || last)) state_nx = OWN0;
        else if (Req1)               state_nx = OWN1;
      end
      OWN0, OWN1: begin
        // A saturated count (long uncontested run) also yields to a waiter.
        if (own_req && !(cnt_inc >= MAX_B && oth_req)) begin
          if (cnt_inc <= MAX_B) cnt_nx = cnt_inc[CW-1:0];
        end else begin
          state_nx = oth_req ? (own ? OWN0 : OWN1) : IDLE;
          cnt_nx   = '0;
          last_nx  = own;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= PORT_AUX;
      rd_tag <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      last   <= last_nx;
      rd_tag <= {Gnt1 & ~Wr1, Gnt0 & ~Wr0};
    end
  end

  assign RValid0 = rd_tag[0];
  assign RValid1 = rd_tag[1];
  assign RData   = Mem_RData;

endmodule
